apb_slave_regbank: RTL and testbench
====================================

APB_SLAVE_REGBANK -- requirements
Module: apb_slave_regbank

Interface
REQ-001 The block SHALL have parameter SEL_INDEX, default 0, meaning the bit of Pselx that selects this slave (0..2).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 0, meaning the number of wait states inserted per access (0..7).
REQ-003 The block SHALL have parameter ID_VALUE, default 32'hA9B0_0001, meaning the read-only contents of register 15.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-low.
REQ-006 Pselx  input  3  one-hot peripheral select from the bridge.
REQ-007 Penable  input  1  APB access-phase strobe.
REQ-008 Pwrite  input  1  1 = write, 0 = read.
REQ-009 Paddr  input  32  byte address.
REQ-010 Pwdata  input  32  write data.
REQ-011 Prdata  output  32  read data.
REQ-012 Pready  output  1  access-complete indication.
REQ-013 Pslverr  output  1  error response, valid only while Pready=1.
REQ-014 proto_err  output  1  sticky APB protocol-violation flag.

Function
REQ-015 sel SHALL be Pselx[SEL_INDEX]; all other Pselx bits SHALL be ignored.
REQ-016 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-017 From IDLE, sel=1 with Penable=0 SHALL move the FSM to SETUP; otherwise it SHALL stay in IDLE.
REQ-018 From SETUP, the FSM SHALL move to ACCESS unconditionally.
  - On the SETUP->ACCESS edge it SHALL latch Paddr, Pwrite and Pwdata.
  - On the same edge it SHALL clear the wait counter.
REQ-019 In ACCESS, the wait counter SHALL increment each cycle while it is below WAIT_CYCLES.
REQ-020 Pready SHALL be combinational: 1 exactly when state=ACCESS and the counter equals WAIT_CYCLES, else 0.
  - With WAIT_CYCLES=0, Pready SHALL be 1 in the first ACCESS cycle.
REQ-021 From ACCESS with Pready=1, the next state SHALL be SETUP if sel=1 and Penable=0 on the following edge, else IDLE.
  - This permits back-to-back transfers.
REQ-022 Register address decode: index = Paddr[5:2]; 16 registers of 32 bits.
  - Registers 0..14 SHALL be read/write.
  - Register 15 SHALL read ID_VALUE.
REQ-023 Error conditions: Pslverr SHALL be 1 with Pready if any of the following holds for the latched access:
  - Paddr[1:0] != 0;
  - Paddr[25:6] != 0;
  - the access is a write to register 15.
REQ-024 A write SHALL commit Pwdata to the register on the edge where state=ACCESS, Pready=1 and Pslverr=0; an errored write SHALL change nothing.
REQ-025 Read data: Prdata SHALL be loaded on the SETUP->ACCESS edge with the addressed register value (or 0 if errored), SHALL hold stable through ACCESS, and SHALL be 0 in IDLE and SETUP.
REQ-026 A read-after-write to the same register in consecutive transfers SHALL return the newly written value.
REQ-027 proto_err SHALL be set, and stay set until reset, if any of the following occurs:
  - Penable=1 while state=IDLE with sel=1;
  - Penable=0 while state=ACCESS;
  - sel=0 while state=ACCESS.
REQ-028 On a protocol violation in ACCESS, the FSM SHALL return to IDLE without committing the write.
REQ-029 Signals in IDLE (X/Z on Paddr, Pwdata or Pwrite) SHALL NOT affect any state or output.

Reset
REQ-030 When rst=0 at a clock edge, the block SHALL apply: state=IDLE, counter=0, Prdata=0, Pready=0, Pslverr=0, proto_err=0, registers 0..14 = 32'h0.
REQ-031 A reset asserted mid-access SHALL abort the transfer with no register update, taking effect on that edge.
REQ-032 Outputs SHALL be undefined-free from the first edge with rst=0.

Verification
REQ-033 SEL_INDEX=2, WAIT_CYCLES=0: write 32'h3333_4444 to 32'h8800_0010 -> Pready=1 and Pslverr=0 in the first ACCESS cycle, then a read of the same address returns Prdata=32'h3333_4444.
REQ-034 WAIT_CYCLES=2: read 32'h8800_003C -> Pready low for 2 ACCESS cycles, high on the 3rd, Prdata=32'hA9B0_0001 throughout ACCESS.
REQ-035 Write to 32'h8800_0012 (misaligned), to 32'h8800_0040 (out of range) and to register 15 -> each returns Pslverr=1 with Pready; read-back of registers 4 and 15 is unchanged.
REQ-036 Transfer with Pselx=3'b010 only -> the FSM stays in IDLE, Prdata=0, Pready=0, no register changes.
REQ-037 Penable held low during ACCESS -> proto_err=1 and the FSM returns to IDLE; proto_err stays 1 until rst=0.
REQ-038 rst=0 during the ACCESS of a write of 32'h1111_2222 to register 1 -> register 1 reads 32'h0 after reset and all outputs are 0.

Source files
------------

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB slave with a 16 x 32-bit register bank
//
// Purpose:
//   APB slave that tracks the transfer with an IDLE/SETUP/ACCESS FSM, inserts
//   WAIT_CYCLES wait states per access, and serves 16 word registers:
//   0..14 read/write, 15 reads back ID_VALUE. Bad addresses and writes to
//   register 15 complete with Pslverr. Bus misuse sets a sticky proto_err.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-low reset
//   Pselx      one-hot select from the bridge, bit SEL_INDEX is ours
//   Penable    access-phase strobe
//   Pwrite     1 = write, 0 = read
//   Paddr      byte address (word index in [5:2])
//   Pwdata     write data
//   Prdata     read data, non-zero only during ACCESS of a good read
//   Pready     transfer complete (combinational from state and wait counter)
//   Pslverr    error response, qualified by Pready
//   proto_err  sticky protocol-violation flag, cleared only by reset

module apb_slave_regbank #(
  parameter int unsigned SEL_INDEX   = 0,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic        proto_err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  localparam logic [2:0] WAIT_LIM = 3'(WAIT_CYCLES);
  localparam logic [3:0] ID_INDEX = 4'hF;

  logic [1:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic        write_q, write_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] prdata_q, prdata_d;
  logic        proto_err_q;
  logic [31:0] regs_q [15];

  logic        sel;
  logic        in_idle;
  logic        in_access;
  logic        pready;
  logic        setup_err;
  logic [31:0] rd_val;
  logic        b2b;
  logic        idle_viol;
  logic        acc_viol;
  logic        commit;

  // Only our select bit and the word-decode bits of Paddr carry meaning.
  logic        unused_bits;
  assign unused_bits = ^{Pselx, Paddr[31:26]};

  assign sel       = Pselx[SEL_INDEX];
  assign in_idle   = (state_q == ST_IDLE);
  assign in_access = (state_q == ST_ACCESS);
  assign pready    = in_access && (cnt_q == WAIT_LIM);

  // Error decode is evaluated on the live bus in SETUP and latched with the
  // address, so the response never depends on what the bus does later.
  assign setup_err = (Paddr[1:0] != 2'b00)
                  || (Paddr[25:6] != 20'd0)
                  || (Pwrite && (Paddr[5:2] == ID_INDEX));

  always_comb begin
    rd_val = '0;
    if (Paddr[5:2] == ID_INDEX) begin
      rd_val = ID_VALUE;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (Paddr[5:2] == 4'(i)) begin
          rd_val = regs_q[i];
        end
      end
    end
  end

  // A master that already presents its next setup phase in the completing
  // cycle is a back-to-back transfer, not a dropped Penable.
  assign b2b       = pready && sel && !Penable;
  assign idle_viol = in_idle && sel && Penable;
  assign acc_viol  = in_access && (!sel || !Penable) && !b2b;
  assign commit    = pready && write_q && !err_q && !acc_viol;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    prdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (sel && !Penable) begin
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
        idx_d   = Paddr[5:2];
        write_d = Pwrite;
        wdata_d = Pwdata;
        err_d   = setup_err;
        if (!Pwrite && !setup_err) begin
          prdata_d = rd_val;
        end
      end
      ST_ACCESS: begin
        if (acc_viol) begin
          state_d = ST_IDLE;
        end else if (pready) begin
          state_d = b2b ? ST_SETUP : ST_IDLE;
        end else begin
          cnt_d    = cnt_q + 3'd1;
          prdata_d = prdata_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      prdata_q    <= '0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < 15; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
      if (idle_viol || acc_viol) begin
        proto_err_q <= 1'b1;
      end
      for (int i = 0; i < 15; i++) begin
        if (commit && (idx_q == 4'(i))) begin
          regs_q[i] <= wdata_q;
        end
      end
    end
  end

  assign Prdata    = prdata_q;
  assign Pready    = pready;
  assign Pslverr   = pready && err_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - scoreboard bench for apb_slave_regbank
//
// Two instances share one bus: dut_a (SEL_INDEX=2, no wait states) and
// dut_b (SEL_INDEX=1, two wait states). Expected responses are queued when
// the access phase is driven and checked by a monitor when Pready rises.

module tb_apb_slave_regbank;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b;
  logic        pslverr_a, pslverr_b;
  logic        proto_err_a, proto_err_b;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sbq_a[$];
  exp_t        sbq_b[$];
  exp_t        ma, mb;
  logic [31:0] model_a [16];
  logic [31:0] model_b [16];

  always #5 clk = ~clk;

  apb_slave_regbank #(.SEL_INDEX(2), .WAIT_CYCLES(0), .ID_VALUE(ID)) dut_a (
    .clk(clk), .rst(rst), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_a), .Pready(pready_a),
    .Pslverr(pslverr_a), .proto_err(proto_err_a)
  );

  apb_slave_regbank #(.SEL_INDEX(1), .WAIT_CYCLES(2), .ID_VALUE(ID)) dut_b (
    .clk(clk), .rst(rst), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata_b), .Pready(pready_b),
    .Pslverr(pslverr_b), .proto_err(proto_err_b)
  );

  // Response monitor: every completed transfer must match the oldest entry.
  always @(negedge clk) begin
    if (pready_a === 1'b1) begin
      n_cmp++;
      if (sbq_a.size() == 0) begin
        n_bad++;
        $display("FAIL resp_a: unexpected Pready, required no response");
      end else begin
        ma = sbq_a.pop_front();
        if ({prdata_a, pslverr_a} !== {ma.rdata, ma.err}) begin
          n_bad++;
          $display("FAIL resp_a: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                   prdata_a, pslverr_a, ma.rdata, ma.err);
        end
      end
    end
    if (pready_b === 1'b1) begin
      n_cmp++;
      if (sbq_b.size() == 0) begin
        n_bad++;
        $display("FAIL resp_b: unexpected Pready, required no response");
      end else begin
        mb = sbq_b.pop_front();
        if ({prdata_b, pslverr_b} !== {mb.rdata, mb.err}) begin
          n_bad++;
          $display("FAIL resp_b: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                   prdata_b, pslverr_b, mb.rdata, mb.err);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    Pselx   = 3'b000;
    Penable = 1'b0;
    Pwrite  = 1'bx;
    Paddr   = 'x;
    Pwdata  = 'x;
  endtask

  task automatic reset_models();
    for (int i = 0; i < 16; i++) begin
      model_a[i] = 32'h0;
      model_b[i] = 32'h0;
    end
    model_a[15] = ID;
    model_b[15] = ID;
  endtask

  function automatic logic addr_err(input logic wr, input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[25:6] != 20'd0) || (wr && (a[5:2] == 4'hF));
  endfunction

  function automatic logic [31:0] expect_rd(input int t, input logic wr, input logic [31:0] a);
    if (wr || addr_err(wr, a)) return 32'h0;
    return (t == 0) ? model_a[a[5:2]] : model_b[a[5:2]];
  endfunction

  task automatic setup_phase(input int t, input logic wr, input logic [31:0] a, input logic [31:0] d);
    Pselx   = (t == 0) ? 3'b100 : 3'b010;
    Penable = 1'b0;
    Pwrite  = wr;
    Paddr   = a;
    Pwdata  = d;
  endtask

  // Runs from the SETUP cycle to the Pready cycle. With last=0 it returns in
  // the Pready cycle so the caller can present the next setup phase.
  task automatic access_phase(input int t, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input bit last,
                              output int waits, output int hold_bad);
    exp_t e;
    bit   done;
    Penable = 1'b1;
    e.err   = addr_err(wr, a);
    e.rdata = expect_rd(t, wr, a);
    if (t == 0) sbq_a.push_back(e);
    else        sbq_b.push_back(e);
    cyc();
    waits    = 0;
    hold_bad = 0;
    done     = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      if (((t == 0) ? pready_a : pready_b) === 1'b1) begin
        done = 1'b1;
      end else begin
        if (((t == 0) ? prdata_a : prdata_b) !== e.rdata) hold_bad++;
        waits++;
        cyc();
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_pready: target %0d no Pready within 16 cycles, required Pready=1", t);
    end else if (wr && !e.err) begin
      if (t == 0) model_a[a[5:2]] = d;
      else        model_b[a[5:2]] = d;
    end
    if (last) begin
      cyc();
      bus_idle();
    end
  endtask

  task automatic xfer(input int t, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int w, h;
    setup_phase(t, wr, a, d);
    cyc();
    access_phase(t, wr, a, d, 1'b1, w, h);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus_idle();
    cyc();
    cyc();
    n_cmp++;
    if ({prdata_a, pready_a, pslverr_a, proto_err_a} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_a: got prdata=%h rdy=%b err=%b perr=%b, required all 0",
               prdata_a, pready_a, pslverr_a, proto_err_a);
    end
    n_cmp++;
    if ({prdata_b, pready_b, pslverr_b, proto_err_b} !== 35'h0) begin
      n_bad++;
      $display("FAIL reset_b: got prdata=%h rdy=%b err=%b perr=%b, required all 0",
               prdata_b, pready_b, pslverr_b, proto_err_b);
    end
    rst = 1'b1;
    reset_models();
    cyc();
    xfer(0, 1'b0, 32'h8800_0000, 32'h0);
    xfer(0, 1'b0, 32'h8800_003C, 32'h0);
    xfer(1, 1'b0, 32'h8800_0020, 32'h0);
  endtask

  task automatic test_write_read();
    int w, h;
    setup_phase(0, 1'b1, 32'h8800_0010, 32'h3333_4444);
    cyc();
    access_phase(0, 1'b1, 32'h8800_0010, 32'h3333_4444, 1'b1, w, h);
    n_cmp++;
    if (w !== 0) begin
      n_bad++;
      $display("FAIL wait_a: got %0d wait cycles, required 0", w);
    end
    xfer(0, 1'b0, 32'h8800_0010, 32'h0);
    for (int i = 0; i < 8; i++) begin
      int          t;
      logic [31:0] a, d;
      t = $urandom_range(0, 1);
      a = 32'h8800_0000 | (32'($urandom_range(0, 14)) << 2);
      d = $urandom;
      xfer(t, 1'b1, a, d);
      xfer(t, 1'b0, a, 32'h0);
    end
  endtask

  task automatic test_wait_states();
    int w, h;
    setup_phase(1, 1'b0, 32'h8800_003C, 32'h0);
    cyc();
    access_phase(1, 1'b0, 32'h8800_003C, 32'h0, 1'b1, w, h);
    n_cmp++;
    if (w !== 2) begin
      n_bad++;
      $display("FAIL wait_b: got %0d wait cycles, required 2", w);
    end
    n_cmp++;
    if (h !== 0) begin
      n_bad++;
      $display("FAIL hold_b: Prdata differed from %h in %0d wait cycles, required 0", ID, h);
    end
  endtask

  task automatic test_errors();
    xfer(0, 1'b1, 32'h8800_0012, 32'hDEAD_0001);
    xfer(0, 1'b1, 32'h8800_0040, 32'hDEAD_0002);
    xfer(0, 1'b1, 32'h8800_003C, 32'hDEAD_0003);
    xfer(0, 1'b0, 32'h8800_0010, 32'h0);
    xfer(0, 1'b0, 32'h8800_003C, 32'h0);
    xfer(0, 1'b0, 32'h8800_0000, 32'h0);
    xfer(1, 1'b0, 32'h8800_0011, 32'h0);
    xfer(1, 1'b1, 32'h8900_0008, 32'hDEAD_0004);
    xfer(1, 1'b0, 32'h8800_0008, 32'h0);
  endtask

  task automatic test_wrong_select();
    int w, h;
    setup_phase(1, 1'b1, 32'h8800_0010, 32'hBEEF_0010);
    cyc();
    n_cmp++;
    if ({pready_a, prdata_a} !== 33'h0) begin
      n_bad++;
      $display("FAIL sel_ignore_setup: got rdy=%b prdata=%h on dut_a, required 0/0", pready_a, prdata_a);
    end
    access_phase(1, 1'b1, 32'h8800_0010, 32'hBEEF_0010, 1'b0, w, h);
    n_cmp++;
    if ({pready_a, prdata_a} !== 33'h0) begin
      n_bad++;
      $display("FAIL sel_ignore_access: got rdy=%b prdata=%h on dut_a, required 0/0", pready_a, prdata_a);
    end
    cyc();
    bus_idle();
    xfer(0, 1'b0, 32'h8800_0010, 32'h0);
    xfer(1, 1'b0, 32'h8800_0010, 32'h0);
  endtask

  task automatic test_back_to_back();
    int w, h;
    for (int t = 0; t < 2; t++) begin
      setup_phase(t, 1'b1, 32'h8800_0014, 32'h5555_0000 + 32'(t));
      cyc();
      access_phase(t, 1'b1, 32'h8800_0014, 32'h5555_0000 + 32'(t), 1'b0, w, h);
      setup_phase(t, 1'b0, 32'h8800_0014, 32'h0);
      cyc();
      access_phase(t, 1'b0, 32'h8800_0014, 32'h0, 1'b0, w, h);
      setup_phase(t, 1'b0, 32'h8800_003C, 32'h0);
      cyc();
      access_phase(t, 1'b0, 32'h8800_003C, 32'h0, 1'b1, w, h);
    end
  endtask

  task automatic test_proto_err();
    setup_phase(1, 1'b1, 32'h8800_000C, 32'h5A5A_5A5A);
    cyc();
    Penable = 1'b1;
    cyc();
    Penable = 1'b0;
    cyc();
    bus_idle();
    n_cmp++;
    if ({proto_err_b, pready_b, prdata_b} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL proto_access_b: got perr=%b rdy=%b prdata=%h, required 1/0/0",
               proto_err_b, pready_b, prdata_b);
    end
    cyc();
    xfer(1, 1'b0, 32'h8800_000C, 32'h0);
    n_cmp++;
    if ({proto_err_b, proto_err_a} !== 2'b10) begin
      n_bad++;
      $display("FAIL proto_sticky_b: got perr_b=%b perr_a=%b, required 1/0", proto_err_b, proto_err_a);
    end
    Pselx   = 3'b100;
    Penable = 1'b1;
    Pwrite  = 1'b0;
    Paddr   = 32'h8800_0000;
    cyc();
    bus_idle();
    n_cmp++;
    if ({proto_err_a, pready_a} !== 2'b10) begin
      n_bad++;
      $display("FAIL proto_idle_a: got perr=%b rdy=%b, required 1/0", proto_err_a, pready_a);
    end
    cyc();
    xfer(0, 1'b0, 32'h8800_003C, 32'h0);
    n_cmp++;
    if (proto_err_a !== 1'b1) begin
      n_bad++;
      $display("FAIL proto_sticky_a: got perr=%b, required 1", proto_err_a);
    end
  endtask

  task automatic test_reset_mid_access();
    exp_t e;
    setup_phase(0, 1'b1, 32'h8800_0004, 32'h1111_2222);
    cyc();
    Penable = 1'b1;
    e.rdata = 32'h0;
    e.err   = 1'b0;
    sbq_a.push_back(e);
    cyc();
    rst = 1'b0;
    cyc();
    bus_idle();
    n_cmp++;
    if ({prdata_a, pready_a, pslverr_a, proto_err_a} !== 35'h0) begin
      n_bad++;
      $display("FAIL midreset_a: got prdata=%h rdy=%b err=%b perr=%b, required all 0",
               prdata_a, pready_a, pslverr_a, proto_err_a);
    end
    n_cmp++;
    if ({prdata_b, pready_b, pslverr_b, proto_err_b} !== 35'h0) begin
      n_bad++;
      $display("FAIL midreset_b: got prdata=%h rdy=%b err=%b perr=%b, required all 0",
               prdata_b, pready_b, pslverr_b, proto_err_b);
    end
    cyc();
    rst = 1'b1;
    reset_models();
    cyc();
    xfer(0, 1'b0, 32'h8800_0004, 32'h0);
    xfer(0, 1'b0, 32'h8800_0010, 32'h0);
    xfer(1, 1'b0, 32'h8800_0014, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    bus_idle();
    reset_models();
    test_reset();
    test_write_read();
    test_wait_states();
    test_errors();
    test_wrong_select();
    test_back_to_back();
    test_proto_err();
    test_reset_mid_access();
    cyc();
    cyc();
    n_cmp++;
    if ((sbq_a.size() != 0) || (sbq_b.size() != 0)) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d/%0d responses outstanding, required 0/0",
               sbq_a.size(), sbq_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
